// File: rtl/pwm_fade_ctrl.sv
// Purpose: PWM generator whose duty fades, one STEP per period, toward a target picked by a debounced 3-bit switch code.
// Latency: pwm/wrap/busy are registered from next-state values; a switch change reaches level after 2 sync + DEB stable cycles.
// Backpressure: none; free-running, the switches are sampled every cycle and nothing can stall the block.
// Ports: clk, reset (async, active-high); sw1..sw3 raw switches, code {sw3,sw2,sw1};
//        pwm/led0 PWM output; level accepted code; busy ramp in progress; wrap last cycle of period; duty high cycles per period.
module pwm_fade_ctrl #(
  parameter int unsigned PERIOD = 12500,
  parameter int unsigned STEP   = 125,
  parameter int unsigned DEB    = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sw1,
  input  logic        sw2,
  input  logic        sw3,
  output logic        pwm,
  output logic        led0,
  output logic [2:0]  level,
  output logic        busy,
  output logic        wrap,
  output logic [31:0] duty
);

  typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;

  localparam logic [31:0] PERIOD_W = 32'(PERIOD);
  localparam logic [31:0] LAST     = 32'(PERIOD - 1);
  localparam logic [31:0] STEP_W   = 32'(STEP);
  localparam logic [31:0] DEB_LAST = 32'(DEB - 1);
  localparam logic [31:0] BASE     = 32'(PERIOD / 10);
  localparam logic [31:0] SPAN     = 32'((PERIOD * 8) / 10);

  // Target duty for a given switch code: 10% floor plus the 80% span split in 7 steps.
  function automatic logic [31:0] target_of(input logic [2:0] lvl);
    return BASE + (({29'd0, lvl} * SPAN) / 32'd7);
  endfunction

  logic [31:0] count_q, count_d;
  logic [2:0]  sw_meta_q, sw_meta_d;
  logic [2:0]  sw_sync_q, sw_sync_d;
  logic [2:0]  cand_q, cand_d;
  logic [31:0] deb_cnt_q, deb_cnt_d;
  logic [2:0]  level_q, level_d;
  logic [31:0] duty_q, duty_d;
  state_t      state_q, state_d;
  logic        busy_q, busy_d;
  logic        pwm_q, pwm_d;
  logic        wrap_q, wrap_d;
  logic        wrap_now;
  logic [31:0] tgt_cur, tgt_nxt;

  always_comb begin
    wrap_now  = (count_q == LAST);
    count_d   = wrap_now ? 32'd0 : count_q + 32'd1;

    sw_meta_d = {sw3, sw2, sw1};
    sw_sync_d = sw_meta_q;

    // Debounce: cand_q is the code currently being timed; deb_cnt_q counts
    // how many consecutive cycles it has been seen so far.
    cand_d    = cand_q;
    deb_cnt_d = deb_cnt_q;
    level_d   = level_q;
    if (sw_sync_q == level_q) begin
      cand_d    = level_q;
      deb_cnt_d = 32'd0;
    end else if (sw_sync_q != cand_q) begin
      cand_d    = sw_sync_q;
      deb_cnt_d = 32'd1;
    end else if (deb_cnt_q >= DEB_LAST) begin
      level_d   = sw_sync_q;
      deb_cnt_d = 32'd0;
    end else begin
      deb_cnt_d = deb_cnt_q + 32'd1;
    end

    // The wrap update steps toward the target held before this edge; the
    // next state is judged against the target that will hold after it.
    tgt_cur = target_of(level_q);
    tgt_nxt = target_of(level_d);

    duty_d = duty_q;
    if (wrap_now) begin
      if (duty_q < tgt_cur) begin
        duty_d = ((tgt_cur - duty_q) > STEP_W) ? duty_q + STEP_W : tgt_cur;
      end else if (duty_q > tgt_cur) begin
        // Clamping at tgt_cur (>= 0) also rules out underflow.
        duty_d = ((duty_q - tgt_cur) > STEP_W) ? duty_q - STEP_W : tgt_cur;
      end
    end

    if (duty_d < tgt_nxt) begin
      state_d = UP;
    end else if (duty_d > tgt_nxt) begin
      state_d = DOWN;
    end else begin
      state_d = IDLE;
    end
    busy_d = (state_d != IDLE);

    // High cycles sit at the end of the period; duty 0 never matches.
    pwm_d  = (duty_d != 32'd0) && (count_d >= (PERIOD_W - duty_d));
    wrap_d = (count_d == LAST);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q   <= '0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      cand_q    <= '0;
      deb_cnt_q <= '0;
      level_q   <= '0;
      duty_q    <= '0;
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      pwm_q     <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      count_q   <= count_d;
      sw_meta_q <= sw_meta_d;
      sw_sync_q <= sw_sync_d;
      cand_q    <= cand_d;
      deb_cnt_q <= deb_cnt_d;
      level_q   <= level_d;
      duty_q    <= duty_d;
      state_q   <= state_d;
      busy_q    <= busy_d;
      pwm_q     <= pwm_d;
      wrap_q    <= wrap_d;
    end
  end

  assign pwm   = pwm_q;
  assign led0  = pwm_q;
  assign level = level_q;
  assign busy  = busy_q;
  assign wrap  = wrap_q;
  assign duty  = duty_q;

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
module tb_pwm_fade_ctrl;
  localparam int P = 100;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sw1 = 1'b0, sw2 = 1'b0, sw3 = 1'b0;
  logic        pwm, led0, busy, wrap;
  logic [2:0]  level;
  logic [31:0] duty;

  int total = 0;
  int bad   = 0;

  pwm_fade_ctrl #(.PERIOD(100), .STEP(5), .DEB(4)) dut (
    .clk(clk), .reset(reset), .sw1(sw1), .sw2(sw2), .sw3(sw3),
    .pwm(pwm), .led0(led0), .level(level), .busy(busy), .wrap(wrap), .duty(duty)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic set_sw(input logic [2:0] c);
    {sw3, sw2, sw1} = c;
  endtask

  // Returns at the first negedge after the edge that ends a wrap cycle.
  task automatic next_period(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 250; i++) begin
      @(negedge clk);
      if (wrap === 1'b1) begin
        @(negedge clk);
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Samples one full period starting at count 0.
  task automatic count_high(output int hi, output int first, output int led_mis);
    hi = 0; first = -1; led_mis = 0;
    for (int i = 0; i < P; i++) begin
      if (pwm === 1'b1) begin
        if (first < 0) first = i;
        hi++;
      end
      if (led0 !== pwm) led_mis++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    #2 reset = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (duty !== 32'd0) begin bad++; $display("FAIL reset_duty got=%0d want=0", duty); end
    total++; if (level !== 3'd0) begin bad++; $display("FAIL reset_level got=%0d want=0", level); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (pwm !== 1'b0) begin bad++; $display("FAIL reset_pwm got=%b want=0", pwm); end
    total++; if (led0 !== 1'b0) begin bad++; $display("FAIL reset_led0 got=%b want=0", led0); end
    total++; if (wrap !== 1'b0) begin bad++; $display("FAIL reset_wrap got=%b want=0", wrap); end
    reset = 1'b0;
  endtask

  task automatic test_soft_start;
    bit ok;
    int hi, first, lm;
    @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL soft_busy_start got=%b want=1", busy); end
    next_period(ok);
    total++; if (!ok || duty !== 32'd5) begin bad++; $display("FAIL soft_duty1 got=%0d want=5 ok=%0d", duty, ok); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL soft_busy1 got=%b want=1", busy); end
    next_period(ok);
    total++; if (!ok || duty !== 32'd10) begin bad++; $display("FAIL soft_duty2 got=%0d want=10 ok=%0d", duty, ok); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL soft_busy2 got=%b want=0", busy); end
    count_high(hi, first, lm);
    total++; if (hi !== 10) begin bad++; $display("FAIL soft_high got=%0d want=10", hi); end
    total++; if (first !== 90) begin bad++; $display("FAIL soft_first got=%0d want=90", first); end
    total++; if (lm !== 0) begin bad++; $display("FAIL soft_led0 got=%0d want=0 mismatched cycles", lm); end
  endtask

  task automatic test_glitch;
    set_sw(3'b001);
    repeat (3) @(negedge clk);
    set_sw(3'b000);
    repeat (10) @(negedge clk);
    total++; if (level !== 3'd0) begin bad++; $display("FAIL glitch_level got=%0d want=0", level); end
    total++; if (duty !== 32'd10) begin bad++; $display("FAIL glitch_duty got=%0d want=10", duty); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL glitch_busy got=%b want=0", busy); end
  endtask

  task automatic test_clamp;
    bit ok;
    int exp_up [3];
    int exp_dn [3];
    exp_up = '{15, 20, 21};
    exp_dn = '{16, 11, 10};
    set_sw(3'b001);
    for (int i = 0; i < 3; i++) begin
      next_period(ok);
      total++; if (!ok || duty !== 32'(exp_up[i])) begin bad++; $display("FAIL clamp_up%0d got=%0d want=%0d", i, duty, exp_up[i]); end
    end
    total++; if (level !== 3'd1) begin bad++; $display("FAIL clamp_level got=%0d want=1", level); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL clamp_idle got=%b want=0", busy); end
    next_period(ok);
    total++; if (!ok || duty !== 32'd21) begin bad++; $display("FAIL clamp_hold got=%0d want=21", duty); end
    set_sw(3'b000);
    for (int i = 0; i < 3; i++) begin
      next_period(ok);
      total++; if (!ok || duty !== 32'(exp_dn[i])) begin bad++; $display("FAIL clamp_dn%0d got=%0d want=%0d", i, duty, exp_dn[i]); end
    end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL clamp_dn_idle got=%b want=0", busy); end
  endtask

  task automatic test_reversal;
    bit ok;
    int n;
    int mx;
    set_sw(3'b111);
    n = 0;
    do begin
      next_period(ok);
      n++;
    end while (ok && duty !== 32'd50 && n < 20);
    total++; if (n !== 8 || duty !== 32'd50) begin bad++; $display("FAIL rev_reach50 got n=%0d duty=%0d want n=8 duty=50", n, duty); end
    set_sw(3'b000);
    next_period(ok);
    total++; if (!ok || duty !== 32'd45) begin bad++; $display("FAIL rev_first got=%0d want=45", duty); end
    mx = int'(duty);
    n = 0;
    while (ok && duty !== 32'd10 && n < 20) begin
      next_period(ok);
      n++;
      if (int'(duty) > mx) mx = int'(duty);
    end
    total++; if (n !== 7 || duty !== 32'd10) begin bad++; $display("FAIL rev_down got n=%0d duty=%0d want n=7 duty=10", n, duty); end
    total++; if (mx > 55) begin bad++; $display("FAIL rev_overshoot got max=%0d want<=55", mx); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rev_idle got=%b want=0", busy); end
  endtask

  task automatic test_full_ramp;
    bit ok;
    int n, hi, first, lm;
    set_sw(3'b111);
    repeat (8) @(negedge clk);
    total++; if (level !== 3'd7) begin bad++; $display("FAIL full_level got=%0d want=7", level); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL full_busy got=%b want=1", busy); end
    n = 0;
    do begin
      next_period(ok);
      n++;
      total++; if (!ok || duty !== 32'(10 + 5 * n)) begin bad++; $display("FAIL full_step%0d got=%0d want=%0d", n, duty, 10 + 5 * n); end
    end while (ok && duty !== 32'd90 && n < 20);
    total++; if (n !== 16) begin bad++; $display("FAIL full_wraps got=%0d want=16", n); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL full_idle got=%b want=0", busy); end
    count_high(hi, first, lm);
    total++; if (hi !== 90) begin bad++; $display("FAIL full_high got=%0d want=90", hi); end
    total++; if (first !== 10) begin bad++; $display("FAIL full_first got=%0d want=10", first); end
    total++; if (lm !== 0) begin bad++; $display("FAIL full_led0 got=%0d want=0 mismatched cycles", lm); end
  endtask

  task automatic test_async_reset;
    bit ok;
    int n;
    set_sw(3'b011);
    next_period(ok);
    total++; if (!ok || duty !== 32'd85) begin bad++; $display("FAIL arst_pre_duty got=%0d want=85", duty); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL arst_pre_busy got=%b want=1", busy); end
    repeat (37) @(negedge clk);
    total++; if (pwm !== 1'b1) begin bad++; $display("FAIL arst_pre_pwm got=%b want=1", pwm); end
    reset = 1'b1;
    #1;
    total++; if (duty !== 32'd0) begin bad++; $display("FAIL arst_duty got=%0d want=0", duty); end
    total++; if (level !== 3'd0) begin bad++; $display("FAIL arst_level got=%0d want=0", level); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL arst_busy got=%b want=0", busy); end
    total++; if (pwm !== 1'b0) begin bad++; $display("FAIL arst_pwm got=%b want=0", pwm); end
    total++; if (led0 !== 1'b0) begin bad++; $display("FAIL arst_led0 got=%b want=0", led0); end
    total++; if (wrap !== 1'b0) begin bad++; $display("FAIL arst_wrap got=%b want=0", wrap); end
    set_sw(3'b000);
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL arst_soft_busy got=%b want=1", busy); end
      end
      if (wrap === 1'b1) break;
    end
    total++; if (n !== 99) begin bad++; $display("FAIL arst_first_wrap got=%0d want=99 cycles", n); end
    @(negedge clk);
    total++; if (duty !== 32'd5) begin bad++; $display("FAIL arst_soft1 got=%0d want=5", duty); end
    next_period(ok);
    total++; if (!ok || duty !== 32'd10) begin bad++; $display("FAIL arst_soft2 got=%0d want=10", duty); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL arst_soft_idle got=%b want=0", busy); end
  endtask

  initial begin
    test_reset();
    test_soft_start();
    test_glitch();
    test_clamp();
    test_reversal();
    test_full_ramp();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pwm_fade_ctrl.md
PWM_FADE_CTRL -- requirements
Module: pwm_fade_ctrl

Interface
REQ-001 Parameter PERIOD, default 12500: PWM period in clk cycles.
REQ-002 Parameter STEP, default 125: maximum duty change, in cycles, per PWM period.
REQ-003 Parameter DEB, default 50000: number of cycles a switch code must be stable before it is accepted.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 sw1, sw2, sw3  input  1 each  raw asynchronous switches; the code is {sw3,sw2,sw1}, with sw3 as the MSB.
REQ-007 pwm  output  1  registered PWM output.
REQ-008 led0  output  1  copy of pwm.
REQ-009 level  output  3  debounced, accepted switch code; drives led4..led2 externally.
REQ-010 busy  output  1  high while a ramp is in progress.
REQ-011 wrap  output  1  one-cycle pulse on the last cycle of each period.
REQ-012 duty  output  32  current duty, in high cycles per period.

Function
REQ-013 The free-running 32-bit count SHALL cycle 0..PERIOD-1, returning to 0 after PERIOD-1.
REQ-014 wrap SHALL be 1 exactly in cycles where count == PERIOD-1.
REQ-015 Each switch SHALL pass through a 2-flop synchronizer before any other use.
REQ-016 Debounce: a synchronized code that differs from level and stays unchanged for DEB consecutive cycles SHALL be loaded into level; any change restarts the stability count.
REQ-017 Target duty SHALL be PERIOD/10 + floor(level*(PERIOD*8/10)/7), computed in integer arithmetic (default: 1250, 2678, 4107, 5535, 6964, 8392, 9821, 11250).
REQ-018 The FSM SHALL have three states: IDLE (duty == target), UP (duty < target), DOWN (duty > target).
REQ-019 The state SHALL be re-evaluated every cycle from duty and target, so a target change moves the FSM to UP or DOWN on the next cycle.
REQ-020 busy SHALL equal (state != IDLE).
REQ-021 duty SHALL change only on the clock edge that ends a wrap cycle.
REQ-022 In UP, duty SHALL become min(duty+STEP, target).
REQ-023 In DOWN, duty SHALL become max(duty-STEP, target), and SHALL never underflow below 0.
REQ-024 A target reversal mid-ramp SHALL take effect at the next wrap, with no overshoot.
REQ-025 pwm SHALL be high during the cycle in which count >= PERIOD-duty, using that cycle's count and duty values, so each period contains exactly duty high cycles, located at the end of the period.
REQ-026 The pwm register SHALL be computed from next-state values, so the output has no glitches and no extra latency.
REQ-027 duty == 0 SHALL produce a constant-low pwm.
REQ-028 If target and a wrap update coincide on the same edge, the update SHALL use the target value held before that edge.

Reset
REQ-029 While reset is high, count, duty, level, the debounce counter and the synchronizers SHALL be 0, and the state SHALL be IDLE.
REQ-030 While reset is high, pwm, led0, busy and wrap SHALL be 0.
REQ-031 Reset SHALL act asynchronously, including mid-period and mid-ramp.
REQ-032 After reset release, target is 1250 while duty is 0, so the block SHALL soft-start by ramping up.

Verification (sim parameters: PERIOD=100, STEP=5, DEB=4; target table 10, 21, 32, 44, 55, 67, 78, 90)
REQ-033 Soft start: release reset with sw=000 -> busy=1; duty 0 -> 5 -> 10 at the first two wraps; busy falls together with the second update; pwm is then high for count 90..99 only.
REQ-034 Full ramp: sw=111 held >= DEB+3 cycles -> level=7; duty rises 10 -> 90 in 16 wraps; busy=0 after reaching 90; pwm is high for 90 cycles per period.
REQ-035 Glitch: sw1 pulsed high for 3 cycles (< DEB) -> level stays 0; duty and busy are unchanged.
REQ-036 Reversal: while ramping to 90, switch to sw=000 at duty=50 -> the next wrap gives 45, continuing down to 10; duty never exceeds 55.
REQ-037 Clamp: ramp from level 0 to level 1 -> duty goes 10 -> 15 -> 20 -> 21, then IDLE.
REQ-038 Async reset: assert reset at count=37, mid-ramp, without a clock edge -> all outputs read 0 immediately; after release, count restarts at 0 and the soft start repeats.
